// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, instruction
// opcodes, FSM state encoding and the immediate sign-extension helper.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [15:0] sext_imm5(input logic [4:0] imm);
    return {{11{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode decoder: ALU operation, immediate-operand select and
// illegal-opcode flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       imm_sel_o,
  output logic       illegal_o
);

  // Opcode to ALU control
  always_comb begin
    alu_op_o  = ALU_AND;
    imm_sel_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_AND:  alu_op_o = ALU_AND;
      OP_ADD:  alu_op_o = ALU_ADD;
      OP_SUB:  alu_op_o = ALU_SUB;
      OP_ADDI: begin
        alu_op_o  = ALU_ADD;
        imm_sel_o = 1'b1;
      end
      OP_ANDI: begin
        alu_op_o  = ALU_AND;
        imm_sel_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one request, drives an external ALU for a fixed
// settle time, captures the result and flags, and holds the response.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [4:0]  req_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_en,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        flag_z,
  output logic        flag_n
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;

  logic [2:0]  dec_op_s;
  logic        dec_imm_sel_s;
  logic        dec_illegal_s;
  logic        drive_alu_s;

  alu_op_decode u_decode (
    .opcode_i  (req_opcode),
    .alu_op_o  (dec_op_s),
    .imm_sel_o (dec_imm_sel_s),
    .illegal_o (dec_illegal_s)
  );

  // Next-state and datapath capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d  = req_a;
          b_d  = dec_imm_sel_s ? sext_imm5(req_imm) : req_b;
          op_d = dec_op_s;
          if (dec_illegal_s) begin
            // Illegal opcodes bypass the ALU entirely
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = 16'h0000;
          end else begin
            state_d   = ST_ISSUE;
            rsp_err_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = SETTLE_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          rsp_data_d = alu_result;
          flag_z_d   = alu_zero;
          flag_n_d   = alu_neg;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      op_q       <= 3'd0;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
    end
  end

  assign drive_alu_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign req_ready = (state_q == ST_IDLE);
  assign alu_en    = (state_q == ST_WAIT);
  assign alu_a     = drive_alu_s ? a_q  : 16'h0000;
  assign alu_b     = drive_alu_s ? b_q  : 16'h0000;
  assign alu_op    = drive_alu_s ? op_q : 3'd0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response
// scoreboard built from the request stream.
module tb_alu_issue_ctrl;

  localparam int SETTLE = 2;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        fz;
    logic        fn;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_opcode;
  logic [15:0] req_a, req_b;
  logic [4:0]  req_imm;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_en, alu_zero, alu_neg;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        flag_z, flag_n;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];
  logic fz_m = 1'b0;
  logic fn_m = 1'b0;
  int   lat, en_cnt;
  logic [15:0] last_b;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .flag_z(flag_z), .flag_n(flag_n)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a & alu_b;
      3'd1:    alu_result = alu_a + alu_b;
      3'd2:    alu_result = alu_a - alu_b;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
    alu_neg  = alu_result[15];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [4:0] imm);
    exp_t e;
    logic [15:0] simm;
    logic [15:0] r;
    simm = {{11{imm[4]}}, imm};
    r = 16'h0000;
    e.err = 1'b0;
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a + b;
      4'd2:    r = a - b;
      4'd3:    r = a + simm;
      4'd4:    r = a & simm;
      default: e.err = 1'b1;
    endcase
    if (!e.err) begin
      fz_m = (r == 16'h0000);
      fn_m = r[15];
    end
    e.data = r;
    e.fz = fz_m;
    e.fn = fn_m;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request through to response; hold = cycles rsp_ready stays low in RESP
  task automatic run_req(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [4:0] imm, input int hold);
    exp_t e;
    logic [15:0] held;
    check({tag, "_req_ready"}, 16'(req_ready), 16'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_imm = imm;
    sb_q.push_back(model(op, a, b, imm));
    tick();
    req_valid = 1'b0;
    lat = 1; en_cnt = 0; last_b = 16'h0000;
    while (!rsp_valid && lat < 40) begin
      if (alu_en) begin
        en_cnt++;
        last_b = alu_b;
      end
      tick();
      lat++;
    end
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd1);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, rsp_data, held);
      check({tag, "_hold_req_ready"}, 16'(req_ready), 16'd0);
      check({tag, "_hold_valid"}, 16'(rsp_valid), 16'd1);
      tick();
    end
    rsp_ready = 1'b1;
    e = sb_q.pop_front();
    check({tag, "_data"}, rsp_data, e.data);
    check({tag, "_err"}, 16'(rsp_err), 16'(e.err));
    check({tag, "_flag_z"}, 16'(flag_z), 16'(e.fz));
    check({tag, "_flag_n"}, 16'(flag_n), 16'(e.fn));
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, 16'(req_ready), 16'd1);
    check({tag, "_idle_valid"}, 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_opcode = 4'd0; req_a = 16'h0000;
    req_b = 16'h0000; req_imm = 5'd0; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_req_ready", 16'(req_ready), 16'd1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_alu_en", 16'(alu_en), 16'd0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_flags", {14'd0, flag_z, flag_n}, 16'd0);

    run_req("add", 4'd1, 16'h7FFF, 16'h0001, 5'd0, 0);
    check("add_latency", 16'(lat), 16'(2 + SETTLE));
    check("add_en_cycles", 16'(en_cnt), 16'(SETTLE));

    run_req("sub", 4'd2, 16'h0005, 16'h0005, 5'd0, 0);

    run_req("illegal", 4'd7, 16'h1234, 16'h5678, 5'd3, 0);
    check("illegal_latency", 16'(lat), 16'd1);
    check("illegal_en_cycles", 16'(en_cnt), 16'd0);

    run_req("and_hold", 4'd0, 16'hF0F0, 16'h0FF0, 5'd0, 3);

    run_req("andi", 4'd4, 16'hFFFF, 16'h0000, 5'b10000, 0);
    check("andi_alu_b", last_b, 16'hFFF0);

    run_req("addi", 4'd3, 16'h0010, 16'hAAAA, 5'b11111, 0);

    // Reset during the first WAIT cycle discards the request
    req_valid = 1'b1; req_opcode = 4'd1; req_a = 16'h0100; req_b = 16'h8000;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_wait_alu_en", 16'(alu_en), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fz_m = 1'b0; fn_m = 1'b0;
    check("rst_wait_alu_en", 16'(alu_en), 16'd0);
    check("rst_wait_flags", {14'd0, flag_z, flag_n}, 16'd0);
    check("rst_wait_ready", 16'(req_ready), 16'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (rsp_valid) seen++;
        tick();
      end
      check("rst_wait_no_rsp", 16'(seen), 16'd0);
    end

    run_req("add_post_rst", 4'd1, 16'h0001, 16'h0002, 5'd0, 0);
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
